// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access controller: FSM encoding,
// default bus widths and the strobe counter width.
`default_nettype none

package mem_access_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int STRB_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    VSTROBE = 3'd4,
    VHOLD   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_strobe_timer.sv
// Strobe length counter: loads STROBE_CYCLES-1 on start, counts down to zero;
// done is high while the count sits at zero, i.e. during the last strobe cycle.
`default_nettype none

module mem_strobe_timer
  import mem_access_pkg::*;
#(
  parameter int STROBE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic done_o
);

  logic [STRB_CNT_W-1:0] cnt_q;
  logic [STRB_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = STRB_CNT_W'(STROBE_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// Load/store bus initiator for a level-sensitive data memory with address setup/hold.
// Optional store readback verify: define MEM_ACCESS_WRITE_VERIFY_EN.
`default_nettype none

module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q;
  logic              we_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              tmr_start;
  logic              tmr_done;

`ifdef MEM_ACCESS_WRITE_VERIFY_EN
  logic verr_q;
  logic rsp_err_q;
  // The timer is armed in the cycle before each strobe phase, including the readback.
  assign tmr_start = (state_q == SETUP) || ((state_q == HOLD) && we_q);
  assign rsp_err   = rsp_err_q;
`else
  assign tmr_start = (state_q == SETUP);
  assign rsp_err   = 1'b0;
`endif

  mem_strobe_timer #(
    .STROBE_CYCLES (STROBE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (tmr_start),
    .done_o  (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
      verr_q      <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
      rsp_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            mem_addr_q  <= req_addr;
            mem_wdata_q <= req_wdata;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          mem_rd_q <= ~we_q;
          mem_wr_q <= we_q;
          state_q  <= STROBE;
        end
        STROBE: begin
          if (tmr_done) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (!we_q) begin
              rsp_rdata_q <= mem_rdata;
            end
            state_q <= HOLD;
          end
        end
        HOLD: begin
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
          if (we_q) begin
            mem_rd_q <= 1'b1;
            state_q  <= VSTROBE;
          end else begin
            rsp_valid_q <= 1'b1;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
`else
          rsp_valid_q <= 1'b1;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
`endif
        end
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
        VSTROBE: begin
          if (tmr_done) begin
            mem_rd_q <= 1'b0;
            verr_q   <= (mem_rdata != mem_wdata_q);
            state_q  <= VHOLD;
          end
        end
        VHOLD: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= verr_q;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
`endif
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (STROBE_CYCLES=1 and =3 instances).
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_WRITE_VERIFY_EN
  localparam int STORE_LAT1 = 6;
  localparam int STORE_LAT3 = 10;
`else
  localparam int STORE_LAT1 = 4;
  localparam int STORE_LAT3 = 6;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req_valid, req_ready, req_we, rsp_valid, rsp_err, mem_rd, mem_wr;
  logic [4:0] req_addr, mem_addr;
  logic [7:0] req_wdata, rsp_rdata, mem_wdata, mem_rdata;

  logic       req3_valid, req3_ready, req3_we, rsp3_valid, rsp3_err, mem3_rd, mem3_wr;
  logic [4:0] req3_addr, mem3_addr;
  logic [7:0] req3_wdata, rsp3_rdata, mem3_wdata, mem3_rdata;

  logic       mem_init = 1'b0;
  logic       force_b0 = 1'b0;
  logic [7:0] mem1 [32];
  logic [7:0] mem3 [32];

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.ADDR_W(5), .DATA_W(8), .STROBE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_access_ctrl #(.ADDR_W(5), .DATA_W(8), .STROBE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req3_valid), .req_ready(req3_ready), .req_we(req3_we),
    .req_addr(req3_addr), .req_wdata(req3_wdata),
    .rsp_valid(rsp3_valid), .rsp_rdata(rsp3_rdata), .rsp_err(rsp3_err),
    .mem_rd(mem3_rd), .mem_wr(mem3_wr), .mem_addr(mem3_addr),
    .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata)
  );

  // Memory models: level-sensitive writes, combinational reads.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) begin
        mem1[i] <= 8'(i);
        mem3[i] <= 8'(i);
      end
      mem1[0] <= 8'h08;
      mem1[1] <= 8'h02;
      mem1[2] <= 8'h01;
    end else begin
      if (mem_wr)  mem1[mem_addr]  <= mem_wdata;
      if (mem3_wr) mem3[mem3_addr] <= mem3_wdata;
    end
  end

  assign mem_rdata  = mem1[mem_addr] | {7'b0, force_b0};
  assign mem3_rdata = mem3[mem3_addr];

  // Bus-timing monitor on the STROBE_CYCLES=1 instance.
  logic       stab_en = 1'b0;
  logic       prev_strb = 1'b0;
  logic [4:0] prev_addr = '0;
  logic [7:0] prev_wd = '0;
  int         stab_viol = 0;
  int         excl_viol = 0;

  always @(negedge clk) begin
    if (stab_en) begin
      if ((mem_rd || mem_wr || prev_strb) && (mem_addr !== prev_addr || mem_wdata !== prev_wd))
        stab_viol <= stab_viol + 1;
      if (mem_rd && mem_wr)
        excl_viol <= excl_viol + 1;
    end
    prev_strb <= mem_rd || mem_wr;
    prev_addr <= mem_addr;
    prev_wd   <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request on the fast instance from a negedge; returns the number of
  // negedges from the accept edge to the one where rsp_valid is seen high.
  task automatic req1(input string tag, input logic we, input logic [4:0] a,
                      input logic [7:0] d, output int lat);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
  endtask

  int   lat;
  int   n;
  int   acc2, r1n, r2n, wcnt, rsp_seen;
  logic prev_rdy;
  logic [7:0] r1d, r2d;
  logic [4:0] busy_addr;

  initial begin
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    req3_valid = 0; req3_we = 0; req3_addr = '0; req3_wdata = '0;
    mem_init = 1'b1;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    stab_en = 1'b1;

    req1("ld0", 1'b0, 5'd0, 8'h00, lat);
    chk("ld0_lat", 32'(lat), 32'd4);
    chk("ld0_data", 32'(rsp_rdata), 32'h08);

    req1("st31", 1'b1, 5'd31, 8'h5A, lat);
    chk("st31_lat", 32'(lat), 32'(STORE_LAT1));
    chk("st31_err", 32'(rsp_err), 32'd0);
    chk("st31_rdata_held", 32'(rsp_rdata), 32'h08);

    req1("ld31", 1'b0, 5'd31, 8'h00, lat);
    chk("ld31_lat", 32'(lat), 32'd4);
    chk("ld31_data", 32'(rsp_rdata), 32'h5A);

    // Back-to-back loads with req_valid held high.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd1;
    @(posedge clk);
    #1 req_addr = 5'd2;
    acc2 = 0; r1n = 0; r2n = 0; r1d = '0; r2d = '0; prev_rdy = 1'b0; busy_addr = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) busy_addr = mem_addr;
      if (prev_rdy && !req_ready && acc2 == 0) begin
        acc2 = k;
        req_valid = 1'b0;
      end
      if (rsp_valid && r1n == 0) begin
        r1n = k; r1d = rsp_rdata;
      end else if (rsp_valid && r2n == 0) begin
        r2n = k; r2d = rsp_rdata;
      end
      prev_rdy = req_ready;
    end
    req_valid = 1'b0;
    chk("b2b_spacing", 32'(acc2 - 1), 32'd4);
    chk("b2b_busy_addr", 32'(busy_addr), 32'd1);
    chk("b2b_rsp1_cycle", 32'(r1n), 32'd4);
    chk("b2b_rsp1_data", 32'(r1d), 32'h02);
    chk("b2b_rsp2_cycle", 32'(r2n), 32'd8);
    chk("b2b_rsp2_data", 32'(r2d), 32'h01);

    // STROBE_CYCLES=3 instance: store C3 to address 5.
    chk("s3_ready", 32'(req3_ready), 32'd1);
    req3_valid = 1'b1; req3_we = 1'b1; req3_addr = 5'd5; req3_wdata = 8'hC3;
    @(posedge clk);
    #1 req3_valid = 1'b0;
    lat = 0; wcnt = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem3_wr) wcnt++;
      if (rsp3_valid) break;
    end
    chk("s3_lat", 32'(lat), 32'(STORE_LAT3));
    chk("s3_wr_cycles", 32'(wcnt), 32'd3);
    chk("s3_err", 32'(rsp3_err), 32'd0);
    chk("s3_mem", 32'(mem3[5]), 32'hC3);

    // Asynchronous reset during the strobe of a load.
    #1;
    chk("mon_stab", 32'(stab_viol), 32'd0);
    chk("mon_excl", 32'(excl_viol), 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ar_rd_before", 32'(mem_rd), 32'd1);
    stab_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rd_async", 32'(mem_rd), 32'd0);
    chk("ar_ready_async", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    chk("ar_no_rsp", 32'(rsp_seen), 32'd0);
    stab_en = 1'b1;
    req1("ar_ld0", 1'b0, 5'd0, 8'h00, lat);
    chk("ar_ld0_lat", 32'(lat), 32'd4);
    chk("ar_ld0_data", 32'(rsp_rdata), 32'h08);

`ifdef MEM_ACCESS_WRITE_VERIFY_EN
    force_b0 = 1'b1;
    req1("vf_bad", 1'b1, 5'd3, 8'hA4, lat);
    chk("vf_bad_err", 32'(rsp_err), 32'd1);
    chk("vf_bad_lat", 32'(lat), 32'd6);
    force_b0 = 1'b0;
    req1("vf_good", 1'b1, 5'd4, 8'h3C, lat);
    chk("vf_good_err", 32'(rsp_err), 32'd0);
    chk("vf_good_lat", 32'(lat), 32'd6);
    req1("vf_ld", 1'b0, 5'd4, 8'h00, lat);
    chk("vf_ld_lat", 32'(lat), 32'd4);
    chk("vf_ld_data", 32'(rsp_rdata), 32'h3C);
`endif

    @(negedge clk);
    #1;
    chk("mon_stab_end", 32'(stab_viol), 32'd0);
    chk("mon_excl_end", 32'(excl_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
